serial_paralelo_rx: RTL and testbench
=====================================

SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COM, default 8'hBC: comma/idle symbol used for byte alignment.
REQ-002 Parameter ALIGN_CNT, default 4: consecutive aligned COM bytes required before the block reports active.
REQ-003 clk_32f  input  1  sole clock (serial bit rate); all state changes on its rising edge.
REQ-004 reset_L  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  1  serial bit stream, MSB of each byte first, one bit per clk_32f.
REQ-006 data_out  output  8  last completed received byte.
REQ-007 valid_out  output  1  data_out holds a payload byte (not COM).
REQ-008 byte_strobe  output  1  one-cycle pulse at each completed byte boundary while active.
REQ-009 active  output  1  byte alignment is locked.

Function
REQ-010 The 8-bit shift register sr SHALL load {sr[6:0], data_in} on every clk_32f edge out of reset; nxt = {sr[6:0], data_in}.
REQ-011 The FSM SHALL have three states: SEARCH, COUNT and ACTIVE.
REQ-012 SEARCH: when nxt == COM, go to COUNT with bc_cnt=1 and bit_cnt=0, otherwise stay (bit-level sliding search).
REQ-013 COUNT and ACTIVE: bit_cnt (3-bit, wraps 7->0) SHALL increment every edge; a byte completes on the edge where bit_cnt==7.
REQ-014 COUNT at byte completion: if nxt == COM, bc_cnt increments; on reaching ALIGN_CNT, go to ACTIVE; if nxt != COM, go to SEARCH and clear bc_cnt.
REQ-015 ACTIVE SHALL be held until reset (no loss-of-lock detection in this block).
REQ-016 ACTIVE at byte completion: data_out<=nxt, valid_out<=(nxt!=COM), byte_strobe<=1 for exactly one cycle; latency from last bit sampled to data_out is 0 cycles (registered on that edge).
REQ-017 Between completions, data_out and valid_out SHALL hold their values; byte_strobe SHALL be 0.
REQ-018 active SHALL be 1 from the edge that enters ACTIVE; the COM byte completing alignment SHALL NOT produce a strobe.
REQ-019 In SEARCH and COUNT, data_out, valid_out and byte_strobe SHALL stay at reset values.
REQ-020 bc_cnt width SHALL be $clog2(ALIGN_CNT+1) and SHALL saturate at ALIGN_CNT.

Reset
REQ-021 reset_L low SHALL asynchronously force: state=SEARCH, sr=0, bit_cnt=0, bc_cnt=0, data_out=8'h00, valid_out=0, byte_strobe=0, active=0.
REQ-022 Reset asserted mid-byte or mid-alignment SHALL discard all partial state; realignment restarts from SEARCH after release.
REQ-023 The first edge after reset_L rises SHALL shift data_in normally.

Structure
REQ-024 State encodings and the default COM value SHALL reside in the shared phy package, reused by the transmit serializer.
REQ-025 The block SHALL be a single module with no sub-modules; the downstream 4-bit 1-to-2 demux consumes data_out via a separate nibble splitter.

Verification
REQ-026 Reset, then 4 x 8'hBC MSB-first -> active=1 on the last bit edge of the 4th byte, no strobe, data_out=8'h00.
REQ-027 Locked, send 8'hA5 -> one byte_strobe, data_out=8'hA5, valid_out=1 on the 8th bit edge.
REQ-028 Locked, send 8'hBC -> strobe, data_out=8'hBC, valid_out=0.
REQ-029 3 bits of noise, then 3 x BC, then 8'h12, then 4 x BC -> stays in SEARCH/COUNT after 8'h12; active only after the second BC group.
REQ-030 reset_L pulsed low mid-byte while active -> all outputs 0 immediately (asynchronous); 4 BCs are needed again to relock.
REQ-031 Locked random 200-byte stream -> every non-COM byte appears once with valid_out=1; strobe period is exactly 8 cycles.

Source files
------------

// File: rtl/serial_paralelo_rx_pkg.sv
// serial_paralelo_rx_pkg: PHY state encodings and the default comma symbol, shared by the receiver and the transmit serializer.
package serial_paralelo_rx_pkg;
  typedef enum logic [1:0] {SEARCH, COUNT, ACTIVE} state_t;
  localparam logic [7:0] COM_DEFAULT = 8'hBC;
endpackage

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: MSB-first serial-to-byte receiver that aligns on ALIGN_CNT consecutive comma bytes.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [7:0] COM       = COM_DEFAULT,
  parameter int         ALIGN_CNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);
  localparam int BCW = $clog2(ALIGN_CNT + 1);
  state_t         r_state;
  logic [6:0]     r_sr;
  logic [2:0]     r_bit_cnt;
  logic [BCW-1:0] r_bc_cnt;
  logic [7:0]     r_data_out;
  logic           r_valid_out;
  logic           r_byte_strobe;
  logic           r_active;
  logic [7:0]     w_nxt;
  logic           w_is_com;
  logic           w_done;
  // The oldest bit of the 8-bit window is never needed again, so only 7 bits are stored.
  assign w_nxt    = {r_sr, data_in};
  assign w_is_com = w_nxt == COM;
  assign w_done   = r_bit_cnt == 3'd7;
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      r_state       <= SEARCH;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_bc_cnt      <= '0;
      r_data_out    <= 8'h00;
      r_valid_out   <= 1'b0;
      r_byte_strobe <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_sr          <= w_nxt[6:0];
      r_byte_strobe <= 1'b0;
      case (r_state)
        SEARCH: if (w_is_com) begin
          r_state   <= COUNT;
          r_bc_cnt  <= BCW'(1);
          r_bit_cnt <= '0;
        end
        COUNT: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_done && !w_is_com) begin
            r_state  <= SEARCH;
            r_bc_cnt <= '0;
          end else if (w_done) begin
            r_bc_cnt <= r_bc_cnt + BCW'(1);
            if (r_bc_cnt == BCW'(ALIGN_CNT - 1)) begin
              r_state  <= ACTIVE;
              r_active <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_done) begin
            r_data_out    <= w_nxt;
            r_valid_out   <= !w_is_com;
            r_byte_strobe <= 1'b1;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end
  assign data_out    = r_data_out;
  assign valid_out   = r_valid_out;
  assign byte_strobe = r_byte_strobe;
  assign active      = r_active;
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: table-driven, hand-sequenced and random scoreboard checks of the serial receiver.
module tb_serial_paralelo_rx;
  localparam logic [7:0] COM = 8'hBC;
  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;
  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_strobe = -1;
  logic [7:0] model_data = 8'h00;
  logic       model_valid = 1'b0;
  logic [7:0] sb[$];
  int         valid_seen = 0;
  int         nc_sent = 0;
  vec_t       vecs[6];

  serial_paralelo_rx dut (
    .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .byte_strobe(byte_strobe), .active(active)
  );

  always #5 clk_32f = ~clk_32f;
  always @(posedge clk_32f) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset_L = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
    model_data = 8'h00;
    model_valid = 1'b0;
    last_strobe = -1;
  endtask

  // Sends one byte while locked: outputs must hold for 7 bits, then update with a strobe on the 8th.
  task automatic locked_byte(input logic [7:0] v, input logic [7:0] exp_data, input logic exp_valid);
    for (int i = 7; i >= 1; i--) begin
      send_bit(v[i]);
      chk("strobe_low", byte_strobe, 0);
      chk("data_hold", data_out, model_data);
      chk("valid_hold", valid_out, model_valid);
    end
    send_bit(v[0]);
    chk("strobe_high", byte_strobe, 1);
    chk("data_byte", data_out, exp_data);
    chk("valid_byte", valid_out, exp_valid);
    if (last_strobe >= 0) chk("strobe_period", cyc - last_strobe, 8);
    last_strobe = cyc;
    model_data = exp_data;
    model_valid = exp_valid;
  endtask

  task automatic lock_seq(input string tag);
    for (int k = 0; k < 3; k++) begin
      send_byte(COM);
      chk({tag, "_not_yet_active"}, active, 0);
      chk({tag, "_no_strobe_align"}, byte_strobe, 0);
    end
    send_byte(COM);
    chk({tag, "_active"}, active, 1);
    chk({tag, "_no_strobe_lock"}, byte_strobe, 0);
    chk({tag, "_data_lock"}, data_out, 8'h00);
    chk({tag, "_valid_lock"}, valid_out, 0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 1'b1};
    vecs[1] = '{8'hBC, 8'hBC, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1};
    vecs[4] = '{8'hBC, 8'hBC, 1'b0};
    vecs[5] = '{8'h3C, 8'h3C, 1'b1};

    repeat (3) @(posedge clk_32f);
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", valid_out, 0);
    chk("rst_strobe", byte_strobe, 0);
    chk("rst_active", active, 0);
    @(negedge clk_32f);
    reset_L = 1'b1;

    lock_seq("lock1");
    foreach (vecs[i]) locked_byte(vecs[i].tx, vecs[i].exp_data, vecs[i].exp_valid);

    do_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int k = 0; k < 3; k++) send_byte(COM);
    chk("noise_count_inactive", active, 0);
    send_byte(8'h12);
    chk("break_inactive", active, 0);
    chk("break_no_strobe", byte_strobe, 0);
    chk("break_data", data_out, 8'h00);
    lock_seq("lock2");

    locked_byte(8'hA5, 8'hA5, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("async_data", data_out, 8'h00);
    chk("async_valid", valid_out, 0);
    chk("async_strobe", byte_strobe, 0);
    chk("async_active", active, 0);
    @(negedge clk_32f);
    reset_L = 1'b1;
    model_data = 8'h00;
    model_valid = 1'b0;
    last_strobe = -1;
    lock_seq("lock3");

    for (int n = 0; n < 200; n++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (n % 17 == 0) v = COM;
      if (v != COM) begin
        sb.push_back(v);
        nc_sent++;
      end
      locked_byte(v, v, v != COM);
      if (valid_out) begin
        valid_seen++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_byte", data_out, sb.pop_front());
      end
    end
    chk("sb_empty", sb.size(), 0);
    chk("valid_count", valid_seen, nc_sent);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
